// File: rtl/mult_operand_feeder.sv
// Operand sequencer for the repeated-addition multiplier: buffers (A, B) pairs,
// plays the start/A/B bus schedule, waits for done and retires or aborts each job.
module mult_operand_feeder #(
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 65600,
   parameter int TO_W    = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             mul_start,
   output logic [WIDTH-1:0] mul_data,
   output logic             mul_clear,
   input  logic             mul_done,
   output logic             job_done,
   output logic [7:0]       job_tag,
   output logic             timeout_err,
   output logic             busy,
   output logic [2:0]       dbg_state
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ISSUE  = 3'd1,
      S_LOAD_A = 3'd2,
      S_LOAD_B = 3'd3,
      S_WAIT   = 3'd4,
      S_RETIRE = 3'd5,
      S_ABORT  = 3'd6
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mem_a_q [DEPTH];
   logic [WIDTH-1:0] mem_b_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [WIDTH-1:0] b_h_q, mul_data_q;
   logic [TO_W-1:0]  wd_q;
   logic [7:0]       tag_q, job_tag_q;
   logic             mul_start_q, mul_clear_q, job_done_q, timeout_err_q, busy_q;
   logic             push, pop, wd_hit;

   // Handshake: a pair transfers on a rising edge where in_valid and in_ready are both high.
   assign in_ready = (count_q != CNT_W'(DEPTH));
   assign push     = in_valid & in_ready;
   assign pop      = (state_q == S_IDLE) && (count_q != '0);
   assign wd_hit   = (wd_q == TO_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (push) begin
         mem_a_q[wr_ptr_q] <= in_a;
         mem_b_q[wr_ptr_q] <= in_b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (count_q != '0) state_d = S_ISSUE;
         S_ISSUE:  state_d = S_LOAD_A;
         S_LOAD_A: state_d = S_LOAD_B;
         S_LOAD_B: state_d = S_WAIT;
         S_WAIT: begin
            // done takes priority over a watchdog expiring in the same cycle
            if (mul_done)    state_d = S_RETIRE;
            else if (wd_hit) state_d = S_ABORT;
         end
         S_RETIRE: state_d = S_IDLE;
         S_ABORT:  state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         wd_q          <= '0;
         tag_q         <= '0;
         job_tag_q     <= '0;
         b_h_q         <= '0;
         mul_data_q    <= '0;
         mul_start_q   <= 1'b0;
         mul_clear_q   <= 1'b0;
         job_done_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         mul_start_q   <= (state_d == S_ISSUE);
         mul_clear_q   <= (state_d == S_RETIRE) || (state_d == S_ABORT);
         job_done_q    <= (state_d == S_RETIRE);
         timeout_err_q <= (state_d == S_ABORT);
         busy_q        <= (state_d != S_IDLE);

         if (state_q == S_LOAD_B)    wd_q <= '0;
         else if (state_q == S_WAIT) wd_q <= wd_q + TO_W'(1);

         if (pop) begin
            mul_data_q <= mem_a_q[rd_ptr_q];
            b_h_q      <= mem_b_q[rd_ptr_q];
         end else if (state_q == S_LOAD_A) begin
            mul_data_q <= b_h_q;
         end

         if ((state_d == S_RETIRE) || (state_d == S_ABORT)) begin
            job_tag_q <= tag_q;
            tag_q     <= tag_q + 8'd1;
         end
      end
   end

   assign mul_start   = mul_start_q;
   assign mul_data    = mul_data_q;
   assign mul_clear   = mul_clear_q;
   assign job_done    = job_done_q;
   assign job_tag     = job_tag_q;
   assign timeout_err = timeout_err_q;
   assign busy        = busy_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_mult_operand_feeder.sv
// Bench for mult_operand_feeder: directed jobs, a behavioural multiplier done model,
// and a monitor that checks the bus schedule and each retirement against a queue.
module tb_mult_operand_feeder;

   localparam int TO_TB = 20;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_a = '0;
   logic [15:0] in_b = '0;
   logic        mul_start;
   logic [15:0] mul_data;
   logic        mul_clear;
   logic        mul_done = 1'b0;
   logic        job_done;
   logic [7:0]  job_tag;
   logic        timeout_err;
   logic        busy;
   logic [2:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   // expected entry: {timeout, tag, latency from start, a, b}
   logic [48:0] exp_q[$];
   int          dly_q[$];
   int          gap_q[$];
   logic [7:0]  exp_tag = 8'd0;
   int          n_starts = 0;

   mult_operand_feeder #(
      .WIDTH(16), .DEPTH(4), .TIMEOUT(TO_TB), .TO_W(5)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .mul_start(mul_start), .mul_data(mul_data), .mul_clear(mul_clear),
      .mul_done(mul_done), .job_done(job_done), .job_tag(job_tag),
      .timeout_err(timeout_err), .busy(busy), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "bench time limit");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
      end
   endtask

   function automatic logic [48:0] pack(input logic to, input logic [7:0] tag,
                                        input logic [7:0] lat, input logic [15:0] a,
                                        input logic [15:0] b);
      return {to, tag, lat, a, b};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic push_pair(input logic [15:0] a, input logic [15:0] b, input int d);
      int   n;
      logic to;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      n = 0;
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("push_accept", in_ready, 1);
      if (in_ready) begin
         to = (d == 0) || (d > TO_TB);
         exp_q.push_back(pack(to, exp_tag, to ? 8'(TO_TB + 3) : 8'(d + 3), a, b));
         dly_q.push_back(d);
         exp_tag++;
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("drain_queue", exp_q.size(), 0);
      check("drain_busy", busy, 0);
   endtask

   task automatic check_reset_outputs(input string tagname);
      check({tagname, "_in_ready"}, in_ready, 1);
      check({tagname, "_mul_start"}, mul_start, 0);
      check({tagname, "_mul_data"}, mul_data, 0);
      check({tagname, "_mul_clear"}, mul_clear, 0);
      check({tagname, "_job_done"}, job_done, 0);
      check({tagname, "_job_tag"}, job_tag, 0);
      check({tagname, "_timeout_err"}, timeout_err, 0);
      check({tagname, "_busy"}, busy, 0);
   endtask

   // ---------------- multiplier model + monitor / scoreboard ----------------
   int          cyc = 0;
   int          last_end = 0;
   int          cnt = 0;
   int          cur_dly = 0;
   bit          active = 1'b0;
   logic [15:0] a_obs = '0;
   logic [15:0] b_obs = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         active   = 1'b0;
         mul_done = 1'b0;
         cnt      = 0;
      end else begin
         cyc++;
         if (active) begin
            cnt++;
            if (cnt == 1) begin
               check("start_one_cycle", mul_start, 0);
               check("data_load_a", mul_data, a_obs);
            end
            if (cnt == 2) b_obs = mul_data;
            if (cur_dly != 0 && cnt == cur_dly + 2) mul_done = 1'b1;
         end else if (mul_start) begin
            active = 1'b1;
            cnt    = 0;
            a_obs  = mul_data;
            n_starts++;
            gap_q.push_back(cyc - last_end);
            check("start_expected", dly_q.size() != 0, 1);
            cur_dly = (dly_q.size() != 0) ? dly_q.pop_front() : 0;
         end
         if (job_done || timeout_err) begin
            check("retire_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0)
               check("retire_job", pack(timeout_err, job_tag, 8'(cnt), a_obs, b_obs),
                     exp_q.pop_front());
            check("retire_clear", mul_clear, 1);
            check("retire_exclusive", job_done ^ timeout_err, 1);
            check("retire_data_hold", mul_data, b_obs);
            active   = 1'b0;
            last_end = cyc;
            mul_done = 1'b0;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int s0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // single job: A=7, B=5, done in WAIT cycle 6
      push_pair(16'd7, 16'd5, 6);
      wait_idle();
      check("single_start_count", n_starts, 1);

      // back-to-back: four consecutive pushes, one IDLE cycle between jobs
      gap_q.delete();
      check("b2b_ready0", in_ready, 1);
      push_pair(16'h1234, 16'd3, 2);
      check("b2b_ready1", in_ready, 1);
      push_pair(16'hFFFF, 16'd1, 1);
      check("b2b_ready2", in_ready, 1);
      push_pair(16'h0000, 16'd2, 3);
      check("b2b_ready3", in_ready, 1);
      push_pair(16'h8001, 16'd4, 5);
      wait_idle();
      check("b2b_gap_count", gap_q.size(), 4);
      for (int i = 1; i < 4; i++)
         if (i < gap_q.size()) check("b2b_gap", gap_q[i], 2);

      // full FIFO: first job stalls, four more fill the FIFO, fifth waits for space
      push_pair(16'h0101, 16'h0202, 15);
      repeat (6) @(negedge clk);
      push_pair(16'h1111, 16'h0011, 1);
      push_pair(16'h2222, 16'h0022, 2);
      push_pair(16'h3333, 16'h0033, 1);
      push_pair(16'h4444, 16'h0044, 2);
      check("full_ready_low", in_ready, 0);
      check("full_busy", busy, 1);
      push_pair(16'h5555, 16'h0055, 1);
      wait_idle();

      // watchdog: no done -> abort 21 cycles into WAIT, next job gets tag+1
      push_pair(16'hDEAD, 16'h0003, 0);
      push_pair(16'hBEEF, 16'h0004, 4);
      wait_idle();

      // done arriving in the same cycle the watchdog expires
      push_pair(16'hCAFE, 16'h0006, TO_TB);
      push_pair(16'h0F0F, 16'h0007, TO_TB - 1);
      wait_idle();

      // asynchronous reset in the middle of WAIT
      push_pair(16'hAAAA, 16'h5555, 0);
      push_pair(16'h0003, 16'h0003, 1);
      repeat (8) @(negedge clk);
      check("pre_reset_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("async_reset");
      exp_q.delete();
      dly_q.delete();
      exp_tag = 8'd0;
      @(negedge clk);
      @(negedge clk);
      #3 rst_n = 1'b1;
      s0 = n_starts;
      repeat (5) @(negedge clk);
      check("post_reset_idle", busy, 0);
      check("post_reset_no_start", n_starts, s0);
      push_pair(16'h0042, 16'h0009, 3);
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
